mem_sync_rw: RTL and testbench

MEM_SYNC_RW -- requirements
Module: mem_sync_rw

---
 rtl/mem_sync_rw_pkg.sv | 12 +
 rtl/mem_be_array.sv | 34 +++
 rtl/mem_sync_rw.sv | 120 ++++++++++++
 tb/tb_mem_sync_rw.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/mem_sync_rw_pkg.sv
// rtl/mem_sync_rw_pkg.sv - shared types and default geometry for mem_sync_rw
package mem_sync_rw_pkg;

  localparam int DEF_DATA_W = 16;
  localparam int DEF_ADDR_W = 8;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_e;

endpackage

// File: rtl/mem_be_array.sv
// rtl/mem_be_array.sv - storage array with byte-lane writes and combinational read port
// The array has no reset; contents are only ever cleared by the owner's sweep.
module mem_be_array
  import mem_sync_rw_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic                clk,
  input  logic                we,
  input  logic [ADDR_W-1:0]   waddr,
  input  logic [DATA_W-1:0]   wdata,
  input  logic [DATA_W/8-1:0] wbe,
  input  logic [ADDR_W-1:0]   raddr,
  output logic [DATA_W-1:0]   rdata
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam int NB    = DATA_W / 8;

  logic [DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < NB; i++) begin
        if (wbe[i]) mem_q[waddr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  // Read sees the pre-edge word, so a same-cycle write is never visible here.
  assign rdata = mem_q[raddr];

endmodule

// File: rtl/mem_sync_rw.sv
// rtl/mem_sync_rw.sv - byte-lane RAM with clearing sweep, latency-1 reads; MEM_SYNC_RW_BYPASS_EN selects write-to-read bypass
module mem_sync_rw
  import mem_sync_rw_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                wr_en,
  input  logic [ADDR_W-1:0]   wr_addr,
  input  logic [DATA_W-1:0]   wr_data,
  input  logic [DATA_W/8-1:0] wr_be,
  input  logic                rd_req,
  input  logic [ADDR_W-1:0]   rd_addr,
  output logic [DATA_W-1:0]   rd_data,
  output logic                rd_valid,
  output logic                ready
);

  localparam int NB = DATA_W / 8;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   init_cnt_q, init_cnt_d;
  logic                rd_valid_q, rd_valid_d;
  logic [DATA_W-1:0]   rd_data_q, rd_data_d;

  logic                mem_we;
  logic [ADDR_W-1:0]   mem_waddr;
  logic [DATA_W-1:0]   mem_wdata;
  logic [NB-1:0]       mem_wbe;
  logic [DATA_W-1:0]   mem_rdata;
  logic [DATA_W-1:0]   rd_word;
  logic                wr_acc;
  logic                rd_acc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= INIT;
      init_cnt_q <= '0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    case (state_q)
      INIT: begin
        init_cnt_d = init_cnt_q + 1'b1;
        if (init_cnt_q == '1) state_d = RUN;
      end
      RUN:     state_d = RUN;
      default: state_d = INIT;
    endcase
  end

  // The sweep owns the write port during INIT; user requests are dropped.
  always_comb begin
    ready     = 1'b0;
    mem_we    = 1'b1;
    mem_waddr = init_cnt_q;
    mem_wdata = '0;
    mem_wbe   = '1;
    if (state_q == RUN) begin
      ready     = 1'b1;
      mem_we    = wr_en;
      mem_waddr = wr_addr;
      mem_wdata = wr_data;
      mem_wbe   = wr_be;
    end
  end

  assign wr_acc = ready & wr_en;
  assign rd_acc = ready & rd_req;

  always_comb begin
    rd_word = mem_rdata;
`ifdef MEM_SYNC_RW_BYPASS_EN
    if (wr_acc && (wr_addr == rd_addr)) begin
      for (int i = 0; i < NB; i++) begin
        if (wr_be[i]) rd_word[8*i +: 8] = wr_data[8*i +: 8];
      end
    end
`else
    rd_word = mem_rdata;
`endif
  end

  always_comb begin
    rd_valid_d = rd_acc;
    rd_data_d  = rd_acc ? rd_word : rd_data_q;
  end

  assign rd_valid = rd_valid_q;
  assign rd_data  = rd_data_q;

  mem_be_array #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W)
  ) u_array (
    .clk   (clk),
    .we    (mem_we),
    .waddr (mem_waddr),
    .wdata (mem_wdata),
    .wbe   (mem_wbe),
    .raddr (rd_addr),
    .rdata (mem_rdata)
  );

  logic unused_wr_acc;
  assign unused_wr_acc = wr_acc;

endmodule

// File: tb/tb_mem_sync_rw.sv
// tb/tb_mem_sync_rw.sv - randomized and directed checks of mem_sync_rw against a behavioural model
module tb_mem_sync_rw;

  localparam int DEPTH = 256;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wr_en = 1'b0;
  logic [7:0]  wr_addr = '0;
  logic [15:0] wr_data = '0;
  logic [1:0]  wr_be = '0;
  logic        rd_req = 1'b0;
  logic [7:0]  rd_addr = '0;
  logic [15:0] rd_data;
  logic        rd_valid;
  logic        ready;

  always #5 clk = ~clk;

  mem_sync_rw dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .wr_be    (wr_be),
    .rd_req   (rd_req),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .rd_valid (rd_valid),
    .ready    (ready)
  );

  int n_vec = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: a word array, a count of sweep cycles left, and the last read result.
  logic [15:0] ref_mem [DEPTH];
  int          init_left = DEPTH;
  bit          m_ready = 1'b0;
  bit          m_valid = 1'b0;
  logic [15:0] m_data = '0;
  logic [15:0] m_old, m_new;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_ready = 1'b0;
      m_valid = 1'b0;
      m_data = '0;
      init_left = DEPTH;
    end else if (!m_ready) begin
      m_valid = 1'b0;
      init_left--;
      if (init_left == 0) begin
        m_ready = 1'b1;
        foreach (ref_mem[i]) ref_mem[i] = '0;
      end
    end else begin
      m_old = ref_mem[rd_addr];
      m_new = ref_mem[wr_addr];
      if (wr_en) begin
        if (wr_be[0]) m_new[7:0] = wr_data[7:0];
        if (wr_be[1]) m_new[15:8] = wr_data[15:8];
      end
      m_valid = rd_req;
      if (rd_req) begin
        m_data = m_old;
`ifdef MEM_SYNC_RW_BYPASS_EN
        if (wr_en && wr_addr == rd_addr) m_data = m_new;
`endif
      end
      if (wr_en) ref_mem[wr_addr] = m_new;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("ready", {31'b0, ready}, {31'b0, m_ready});
      check("rd_valid", {31'b0, rd_valid}, {31'b0, m_valid});
      check("rd_data", {16'b0, rd_data}, {16'b0, m_data});
    end
  end

  task automatic step(input logic we, input logic [7:0] wa, input logic [15:0] wd,
                      input logic [1:0] be, input logic rr, input logic [7:0] ra);
    wr_en = we; wr_addr = wa; wr_data = wd; wr_be = be;
    rd_req = rr; rd_addr = ra;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(input logic rr, output int cnt);
    cnt = 0;
    while (!ready && cnt < 400) begin
      step(1'b0, 8'h00, 16'h0000, 2'b00, rr, 8'h55);
      cnt++;
    end
    step_idle_inputs();
  endtask

  task automatic step_idle_inputs();
    wr_en = 1'b0; wr_be = '0; rd_req = 1'b0;
  endtask

  task automatic read_expect(input string name, input logic [7:0] a, input logic [15:0] exp);
    step(1'b0, 8'h00, 16'h0000, 2'b00, 1'b1, a);
    check({name, "_valid"}, {31'b0, rd_valid}, 32'd1);
    check(name, {16'b0, rd_data}, {16'b0, exp});
  endtask

  task automatic random_steps(input int n);
    logic [7:0] wa, ra;
    for (int i = 0; i < n; i++) begin
      wa = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 15));
      ra = ($urandom_range(0, 3) == 0) ? wa : 8'($urandom_range(0, 15));
      step(1'($urandom), wa, 16'($urandom), 2'($urandom), 1'($urandom), ra);
    end
    step_idle_inputs();
  endtask

  int cnt;
  int pulses;
  logic [15:0] exp37;

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk_en = 1'b1;
    check("rst_ready", {31'b0, ready}, 32'd0);
    check("rst_rd_valid", {31'b0, rd_valid}, 32'd0);
    check("rst_rd_data", {16'b0, rd_data}, 32'd0);

    rst_n = 1'b1;
    wait_ready(1'b1, cnt);
    check("init_cycles", cnt, 32'd256);
    check("init_read_ignored", {31'b0, rd_valid}, 32'd0);

    read_expect("clr_00", 8'h00, 16'h0000);
    read_expect("clr_7f", 8'h7F, 16'h0000);
    read_expect("clr_ff", 8'hFF, 16'h0000);

    step(1'b1, 8'h10, 16'hBEEF, 2'b11, 1'b0, 8'h00);
    read_expect("full_write", 8'h10, 16'hBEEF);

    step(1'b1, 8'h20, 16'h1234, 2'b11, 1'b0, 8'h00);
    step(1'b1, 8'h20, 16'hAB00, 2'b10, 1'b0, 8'h00);
    read_expect("lane_write", 8'h20, 16'hAB34);

    step(1'b1, 8'h30, 16'h1111, 2'b11, 1'b0, 8'h00);
`ifdef MEM_SYNC_RW_BYPASS_EN
    exp37 = 16'h1122;
`else
    exp37 = 16'h1111;
`endif
    step(1'b1, 8'h30, 16'h2222, 2'b01, 1'b1, 8'h30);
    check("rdw_valid", {31'b0, rd_valid}, 32'd1);
    check("rdw_data", {16'b0, rd_data}, {16'b0, exp37});
    read_expect("rdw_after", 8'h30, 16'h1122);

    for (int i = 0; i < 64; i++) step(1'b1, 8'(8'h40 + i), 16'(16'hA500 + i), 2'b11, 1'b0, 8'h00);
    pulses = 0;
    for (int i = 0; i < 64; i++) begin
      step(1'b0, 8'h00, 16'h0000, 2'b00, 1'b1, 8'(8'h40 + i));
      if (rd_valid) pulses++;
      check("b2b_data", {16'b0, rd_data}, {16'b0, 16'(16'hA500 + i)});
    end
    step(1'b0, 8'h00, 16'h0000, 2'b00, 1'b0, 8'h00);
    check("b2b_tail_valid", {31'b0, rd_valid}, 32'd0);
    check("b2b_hold_data", {16'b0, rd_data}, 32'h0000A53F);
    check("b2b_pulses", pulses, 32'd64);

    random_steps(3000);

    rd_req = 1'b1; rd_addr = 8'h10;
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("rst_mid_valid", {31'b0, rd_valid}, 32'd0);
    check("rst_mid_ready", {31'b0, ready}, 32'd0);
    rst_n = 1'b1;
    rd_req = 1'b0;
    wait_ready(1'b0, cnt);
    check("reinit_cycles", cnt, 32'd256);
    read_expect("reclr_10", 8'h10, 16'h0000);
    read_expect("reclr_20", 8'h20, 16'h0000);
    read_expect("reclr_30", 8'h30, 16'h0000);
    read_expect("reclr_45", 8'h45, 16'h0000);

    random_steps(1500);

    @(negedge clk);
    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
